// File: rtl/alu_pkg.sv
// Shared opcode encodings and datapath widths for the execute-stage ALU.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;

  localparam logic [3:0] ALU_OR   = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_NEG  = 4'd5;
  localparam logic [3:0] ALU_MUL  = 4'd6;
  localparam logic [3:0] ALU_DIV  = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_SHRA = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_ROR  = 4'd12;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the issue logic and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] input_a;
  logic [DATA_W-1:0] input_b;
  logic [3:0]        opcode;
  logic [RES_W-1:0]  ALU_result;

  modport master (
    output input_a,
    output input_b,
    output opcode,
    input  ALU_result
  );

  modport slave (
    input  input_a,
    input  input_b,
    input  opcode,
    output ALU_result
  );

endinterface

// File: rtl/alu_div32.sv
// Combinational signed 32-bit divider; quotient truncates toward zero and
// the remainder follows the sign of the dividend.
module alu_div32
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  // Divide-by-zero and the single overflowing pair are pinned explicitly so
  // the result never depends on how the tools treat those cases.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if (dividend == {1'b1, {(DATA_W-1){1'b0}}} && divisor == '1) begin
      quotient  = dividend;
      remainder = '0;
    end else begin
      quotient  = $signed(dividend) / $signed(divisor);
      remainder = $signed(dividend) % $signed(divisor);
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational datapath with one registered 64-bit result.
// Build option ALU_MULDIV_EN: when defined, the signed multiplier and the
// alu_div32 divider are built; otherwise MUL and DIV return 0.
module alu
  import alu_pkg::*;
(
  input logic  clock,
  input logic  clear,
  alu_if.slave bus
);

  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic [4:0]          amt;
  logic [2*DATA_W-1:0] rot_l;
  logic [2*DATA_W-1:0] rot_r;
  logic [RES_W-1:0]    mul_result;
  logic [RES_W-1:0]    div_result;
  logic [RES_W-1:0]    next_result;

  assign a   = bus.input_a;
  assign b   = bus.input_b;
  assign amt = b[4:0];

  // Rotates as shifts of a doubled word: the wrapped bits land in the
  // half that is kept, and an amount of 0 naturally passes A through.
  assign rot_l = {a, a} << amt;
  assign rot_r = {a, a} >> amt;

`ifdef ALU_MULDIV_EN
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic [DATA_W-1:0]       quo;
  logic [DATA_W-1:0]       rem;

  assign a_ext      = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext      = {{DATA_W{b[DATA_W-1]}}, b};
  assign mul_result = a_ext * b_ext;

  alu_div32 u_div (
    .dividend  (a),
    .divisor   (b),
    .quotient  (quo),
    .remainder (rem)
  );

  assign div_result = {rem, quo};
`else
  assign mul_result = '0;
  assign div_result = '0;
`endif

  // Opcode decode; upper word stays zero except for MUL and DIV.
  always_comb begin
    next_result = '0;
    case (bus.opcode)
      ALU_OR:   next_result[DATA_W-1:0] = a | b;
      ALU_AND:  next_result[DATA_W-1:0] = a & b;
      ALU_NOT:  next_result[DATA_W-1:0] = ~a;
      ALU_ADD:  next_result[DATA_W-1:0] = a + b;
      ALU_SUB:  next_result[DATA_W-1:0] = a - b;
      ALU_NEG:  next_result[DATA_W-1:0] = -a;
      ALU_MUL:  next_result = mul_result;
      ALU_DIV:  next_result = div_result;
      ALU_SHL:  next_result[DATA_W-1:0] = a << amt;
      ALU_SHR:  next_result[DATA_W-1:0] = a >> amt;
      ALU_SHRA: next_result[DATA_W-1:0] = $signed(a) >>> amt;
      ALU_ROL:  next_result[DATA_W-1:0] = rot_l[2*DATA_W-1:DATA_W];
      ALU_ROR:  next_result[DATA_W-1:0] = rot_r[DATA_W-1:0];
      default:  next_result = '0;
    endcase
  end

  // Result register; clear forces zero immediately and holds it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) bus.ALU_result <= '0;
    else        bus.ALU_result <= next_result;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset/latency behaviour,
// and randomized operations against a plain-arithmetic reference model.
module tb_alu;

  logic clock;
  logic clear;
  int   pass_cnt;
  int   total_cnt;

  alu_if bus ();

  alu dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam longint M32 = 64'sh1_0000_0000;

  // Reference model: modular / floor arithmetic on wide integers.
  function automatic logic [63:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb, pow, q, r, lo, qm, rm;
    int n;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    pow = 1;
    for (int i = 0; i < n; i++) pow = pow * 2;
    lo = 0;
    case (op)
      4'd0: lo = longint'(a | b);
      4'd1: lo = longint'(a & b);
      4'd2: lo = longint'(~a);
      4'd3: lo = (ua + ub) % M32;
      4'd4: lo = (ua - ub + M32) % M32;
      4'd5: lo = (M32 - ua) % M32;
`ifdef ALU_MULDIV_EN
      4'd6: return 64'(sa * sb);
      4'd7: begin
        if (sb == 0) begin
          q = -1;
          r = sa;
        end else begin
          qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          rm = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
          q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
          r  = (sa < 0) ? -rm : rm;
        end
        return {32'(r), 32'(q)};
      end
`endif
      4'd8:  lo = (ua * pow) % M32;
      4'd9:  lo = ua / pow;
      4'd10: lo = (sa >= 0) ? sa / pow : -((-sa + pow - 1) / pow);
      4'd11: lo = ((ua * pow) % M32) + ua / (M32 / pow);
      4'd12: begin
        pow = 1;
        for (int i = 0; i < (32 - n) % 32; i++) pow = pow * 2;
        lo = ((ua * pow) % M32) + ua / (M32 / pow);
      end
      default: lo = 0;
    endcase
    return {32'h0, 32'(lo)};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.opcode  = op;
    bus.input_a = a;
    bus.input_b = b;
  endtask

  task automatic test_reset();
    clear       = 1'b0;
    bus.opcode  = 4'd3;
    bus.input_a = 32'd20;
    bus.input_b = 32'd5;
    #3;
    total_cnt++;
    if (bus.ALU_result !== 64'h0)
      $display("FAIL reset_initial: got %h want %h", bus.ALU_result, 64'h0);
    else pass_cnt++;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'h0)
      $display("FAIL reset_hold: got %h want %h", bus.ALU_result, 64'h0);
    else pass_cnt++;
    @(negedge clock);
    clear = 1'b1;
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'h0)
      $display("FAIL release_no_edge: got %h want %h", bus.ALU_result, 64'h0);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'd25)
      $display("FAIL release_first_edge: got %h want %h", bus.ALU_result, 64'd25);
    else pass_cnt++;
  endtask

  logic [3:0]  d_op  [24] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd6,
                             4'd6, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8, 4'd9, 4'd11,
                             4'd12, 4'd10, 4'd14, 4'd7, 4'd5, 4'd8, 4'd11, 4'd9};
  logic [31:0] d_a   [24] = '{32'd20, 32'd20, 32'd20, 32'd20, 32'd20, 32'd20,
                             32'hFFFFFFFF, 32'd20, 32'hFFFFFFFD, 32'h80000000,
                             32'd20, 32'hFFFFFFF9, 32'd9, 32'hB2, 32'hB2, 32'hB2,
                             32'hB2, 32'h80000000, 32'd20, 32'h80000000,
                             32'h80000000, 32'h1234, 32'hB2, 32'hB2};
  logic [31:0] d_b   [24] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd1,
                             32'd5, 32'd7, 32'h80000000, 32'd5, 32'd2, 32'd0,
                             32'd2, 32'd2, 32'd2, 32'd2, 32'd4, 32'd5,
                             32'hFFFFFFFF, 32'd0, 32'h20, 32'd0, 32'hFFFFFFE1};
  logic [63:0] d_exp [24] = '{64'd21, 64'd4, 64'h0000_0000_FFFF_FFEB, 64'd25,
                             64'd15, 64'h0000_0000_FFFF_FFEC, 64'd0, 64'd100,
                             64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                             64'h0000_0000_0000_0004, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0009_FFFF_FFFF, 64'h2C8, 64'h2C, 64'h2C8,
                             64'h8000_002C, 64'hF800_0000, 64'd0,
                             64'h0000_0000_8000_0000, 64'h8000_0000, 64'h1234,
                             64'hB2, 64'h59};

  task automatic test_directed();
    logic [63:0] want;
    for (int i = 0; i < 24; i++) begin
      want = d_exp[i];
`ifndef ALU_MULDIV_EN
      if (d_op[i] == 4'd6 || d_op[i] == 4'd7) want = 64'd0;
`endif
      drive(d_op[i], d_a[i], d_b[i]);
      @(posedge clock);
      #1;
      total_cnt++;
      if (bus.ALU_result !== want)
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: got %h want %h",
                 i, d_op[i], d_a[i], d_b[i], bus.ALU_result, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_midstream_clear();
    drive(4'd0, 32'd20, 32'd5);
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'd21)
      $display("FAIL clear_pre: got %h want %h", bus.ALU_result, 64'd21);
    else pass_cnt++;
    #2;
    clear = 1'b0;
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'h0)
      $display("FAIL clear_async: got %h want %h", bus.ALU_result, 64'h0);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'h0)
      $display("FAIL clear_held_edge: got %h want %h", bus.ALU_result, 64'h0);
    else pass_cnt++;
    drive(4'd3, 32'd20, 32'd5);
    clear = 1'b1;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'd25)
      $display("FAIL clear_release_add: got %h want %h", bus.ALU_result, 64'd25);
    else pass_cnt++;
  endtask

  task automatic test_hold_inputs();
    drive(4'd3, 32'd1, 32'd2);
    @(posedge clock);
    #1;
    bus.opcode  = 4'd4;
    bus.input_a = 32'd100;
    bus.input_b = 32'd1;
    #3;
    total_cnt++;
    if (bus.ALU_result !== 64'd3)
      $display("FAIL midcycle_hold: got %h want %h", bus.ALU_result, 64'd3);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.ALU_result !== 64'd99)
      $display("FAIL midcycle_next_edge: got %h want %h", bus.ALU_result, 64'd99);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    for (int op = 0; op < 16; op++) begin
      drive(4'(op), 32'h8765_4321, 32'hFFFF_FFF3);
      want = ref_alu(4'(op), 32'h8765_4321, 32'hFFFF_FFF3);
      @(posedge clock);
      #1;
      total_cnt++;
      if (bus.ALU_result !== want)
        $display("FAIL b2b op=%0d: got %h want %h", op, bus.ALU_result, want);
      else pass_cnt++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] want;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      want = ref_alu(op, a, b);
      drive(op, a, b);
      @(posedge clock);
      #1;
      total_cnt++;
      if (bus.ALU_result !== want)
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h want %h",
                 i, op, a, b, bus.ALU_result, want);
      else pass_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_midstream_clear();
    test_hold_inputs();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
